// File: rtl/icache_sa.sv
// icache_sa: set-associative instruction cache between fetch (IF) and memory controller (MC)
// Ports: clk_in/rst_in (async active-low), rdy_in global enable, flush_in abandons a fetch,
//        inv_all_in invalidates every line; IF_query_* in, IF_dout_* out; MC_query_* out,
//        MC_data_* in (one whole line per return).
module icache_sa #(
  parameter int SET_WIDTH   = 2,
  parameter int WAY_WIDTH   = 1,
  parameter int BLOCK_WIDTH = 2,
  parameter int TAG_WIDTH   = 32 - SET_WIDTH - BLOCK_WIDTH - 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          flush_in,
  input  logic                          inv_all_in,
  input  logic                          IF_query_en,
  input  logic [31:0]                   IF_query_addr,
  output logic                          IF_dout_en,
  output logic [31:0]                   IF_dout,
  output logic                          MC_query_en,
  output logic [31:0]                   MC_query_addr,
  input  logic                          MC_data_en,
  input  logic [(32<<BLOCK_WIDTH)-1:0]  MC_data
);
  localparam int SETS = 1 << SET_WIDTH;
  localparam int WAYS = 1 << WAY_WIDTH;
  localparam int WORDS = 1 << BLOCK_WIDTH;
  localparam int LW = 32 << BLOCK_WIDTH;
  localparam int SW = SET_WIDTH > 0 ? SET_WIDTH : 1;
  localparam int PW = WAY_WIDTH > 0 ? WAY_WIDTH : 1;
  localparam int OW = BLOCK_WIDTH > 0 ? BLOCK_WIDTH : 1;
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DRAIN = 2'd2;
  logic [1:0] state_q, state_d;
  logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
  logic [SETS-1:0][PW-1:0] ptr_q;
  logic [TAG_WIDTH-1:0] tag_q [SETS][WAYS];
  logic [LW-1:0] line_q [SETS][WAYS];
  logic [31:0] addr_q, addr_d, dout_d, mca_d;
  logic inv_q, inv_d, dout_en_d, mcq_d;
  logic [SW-1:0] q_set, f_set;
  logic [TAG_WIDTH-1:0] q_tag, f_tag;
  logic [OW-1:0] q_off, f_off;
  logic [PW-1:0] hit_way, fill_way;
  logic [31:0] hit_word, fill_word;
  logic hit, busy, wr, all_valid;
  function automatic logic [31:0] pick(input logic [LW-1:0] l, input logic [OW-1:0] o);
    pick = l[31:0];
    for (int k = 0; k < WORDS; k++) if (o == OW'(k)) pick = l[32*k +: 32];
  endfunction
  assign q_set = SW'((IF_query_addr >> (BLOCK_WIDTH + 2)) & 32'(SETS - 1));
  assign q_tag = TAG_WIDTH'(IF_query_addr >> (SET_WIDTH + BLOCK_WIDTH + 2));
  assign q_off = OW'((IF_query_addr >> 2) & 32'(WORDS - 1));
  assign f_set = SW'((addr_q >> (BLOCK_WIDTH + 2)) & 32'(SETS - 1));
  assign f_tag = TAG_WIDTH'(addr_q >> (SET_WIDTH + BLOCK_WIDTH + 2));
  assign f_off = OW'((addr_q >> 2) & 32'(WORDS - 1));
  assign busy = state_q != IDLE;
  // a fill is dropped when an invalidate is pending or arrives with the data
  assign wr = rdy_in && busy && MC_data_en && !inv_q && !inv_all_in;
  assign all_valid = &valid_q[f_set];
  assign hit_word = pick(line_q[q_set][hit_way], q_off);
  assign fill_word = pick(MC_data, f_off);
  assign inv_d = (busy && MC_data_en) ? 1'b0 : inv_q | (busy && inv_all_in);
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[q_set][w] && tag_q[q_set][w] == q_tag) begin
        hit = 1'b1;
        hit_way = PW'(w);
      end
    hit = hit && !inv_all_in;
  end
  // lowest invalid way wins; the victim pointer is used only when the set is full
  always_comb begin
    fill_way = ptr_q[f_set];
    for (int w = WAYS - 1; w >= 0; w--) if (!valid_q[f_set][w]) fill_way = PW'(w);
  end
  always_comb begin
    valid_d = inv_all_in ? '0 : valid_q;
    if (wr) valid_d[f_set][fill_way] = 1'b1;
  end
  always_comb begin
    state_d = state_q;
    dout_en_d = 1'b0;
    dout_d = IF_dout;
    mcq_d = 1'b0;
    mca_d = MC_query_addr;
    addr_d = addr_q;
    if (state_q == IDLE && IF_query_en && !flush_in) begin
      if (hit) begin
        dout_en_d = 1'b1;
        dout_d = hit_word;
      end else begin
        addr_d = IF_query_addr;
        mcq_d = 1'b1;
        mca_d = IF_query_addr & ~32'((LW / 8) - 1);
        state_d = WAIT;
      end
    end else if (state_q == WAIT && MC_data_en) begin
      state_d = IDLE;
      dout_en_d = !flush_in;
      dout_d = flush_in ? IF_dout : fill_word;
    end else if (state_q == WAIT && flush_in) begin
      state_d = DRAIN;
    end else if (state_q == DRAIN && MC_data_en) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      valid_q <= '0;
      ptr_q <= '0;
      inv_q <= 1'b0;
      addr_q <= '0;
      IF_dout_en <= 1'b0;
      IF_dout <= '0;
      MC_query_en <= 1'b0;
      MC_query_addr <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      valid_q <= valid_d;
      inv_q <= inv_d;
      addr_q <= addr_d;
      IF_dout_en <= dout_en_d;
      IF_dout <= dout_d;
      MC_query_en <= mcq_d;
      MC_query_addr <= mca_d;
      if (wr && all_valid) ptr_q[f_set] <= PW'((32'(ptr_q[f_set]) + 32'd1) & 32'(WAYS - 1));
    end
  end
  always_ff @(posedge clk_in) begin
    if (wr) begin
      tag_q[f_set][fill_way] <= f_tag;
      line_q[f_set][fill_way] <= MC_data;
    end
  end
endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: directed self-checking bench for icache_sa with default geometry
module tb_icache_sa;
  logic clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, flush_in = 1'b0, inv_all_in = 1'b0;
  logic IF_query_en = 1'b0, MC_data_en = 1'b0;
  logic [31:0] IF_query_addr = '0;
  logic [127:0] MC_data = '0;
  logic IF_dout_en, MC_query_en;
  logic [31:0] IF_dout, MC_query_addr;
  int checks = 0, errors = 0;
  icache_sa dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .inv_all_in(inv_all_in), .IF_query_en(IF_query_en), .IF_query_addr(IF_query_addr),
    .IF_dout_en(IF_dout_en), .IF_dout(IF_dout), .MC_query_en(MC_query_en),
    .MC_query_addr(MC_query_addr), .MC_data_en(MC_data_en), .MC_data(MC_data)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // word k of line at base b is (b<<4) | (k+1)*0x11, so line 0 holds 0x11,0x22,0x33,0x44
  function automatic logic [127:0] line_of(input logic [31:0] b);
    logic [31:0] h;
    h = b << 4;
    return {h | 32'h44, h | 32'h33, h | 32'h22, h | 32'h11};
  endfunction
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  task automatic query(input logic [31:0] a);
    IF_query_en = 1'b1;
    IF_query_addr = a;
    tick();
    IF_query_en = 1'b0;
  endtask
  task automatic ret(input logic [31:0] b);
    MC_data_en = 1'b1;
    MC_data = line_of(b);
    tick();
    MC_data_en = 1'b0;
  endtask
  task automatic miss(input string t, input logic [31:0] a, input logic [31:0] b, input logic [31:0] w);
    query(a);
    chk({t, "_mcq"}, {31'd0, MC_query_en}, 32'd1);
    chk({t, "_mca"}, MC_query_addr, b);
    chk({t, "_nodout"}, {31'd0, IF_dout_en}, 32'd0);
    tick();
    chk({t, "_mcq_pulse"}, {31'd0, MC_query_en}, 32'd0);
    ret(b);
    chk({t, "_fill_en"}, {31'd0, IF_dout_en}, 32'd1);
    chk({t, "_fill_word"}, IF_dout, w);
  endtask
  task automatic hit(input string t, input logic [31:0] a, input logic [31:0] w);
    query(a);
    chk({t, "_en"}, {31'd0, IF_dout_en}, 32'd1);
    chk({t, "_word"}, IF_dout, w);
    chk({t, "_nomc"}, {31'd0, MC_query_en}, 32'd0);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_dout_en", {31'd0, IF_dout_en}, 32'd0);
    chk("rst_dout", IF_dout, 32'd0);
    chk("rst_mcq", {31'd0, MC_query_en}, 32'd0);
    chk("rst_mca", MC_query_addr, 32'd0);
    rst_in = 1'b1;
    tick();
    miss("cold", 32'h08, 32'h00, 32'h33);
    hit("cold_hit", 32'h0C, 32'h44);
    tick();
    chk("pulse_one", {31'd0, IF_dout_en}, 32'd0);
    chk("dout_hold", IF_dout, 32'h44);
    miss("fill_w1", 32'h40, 32'h40, 32'h411);
    miss("evict_w0", 32'h80, 32'h80, 32'h811);
    hit("keep_40", 32'h40, 32'h411);
    miss("refill_00", 32'h00, 32'h00, 32'h11);
    hit("keep_80", 32'h80, 32'h811);
    miss("evicted_40", 32'h40, 32'h40, 32'h411);
    query(32'h100);
    chk("fl_mca", MC_query_addr, 32'h100);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    chk("fl_wait", {31'd0, IF_dout_en}, 32'd0);
    ret(32'h100);
    chk("fl_drain", {31'd0, IF_dout_en}, 32'd0);
    hit("fl_rehit", 32'h100, 32'h1011);
    query(32'h1C0);
    tick();
    flush_in = 1'b1;
    ret(32'h1C0);
    flush_in = 1'b0;
    chk("fl_data_en", {31'd0, IF_dout_en}, 32'd0);
    hit("fl_data_hit", 32'h1C0, 32'h1C11);
    flush_in = 1'b1;
    query(32'h200);
    flush_in = 1'b0;
    chk("fl_q_mcq", {31'd0, MC_query_en}, 32'd0);
    chk("fl_q_dout", {31'd0, IF_dout_en}, 32'd0);
    miss("inv_prep", 32'h40, 32'h40, 32'h411);
    hit("inv_prep_hit", 32'h40, 32'h411);
    inv_all_in = 1'b1;
    tick();
    inv_all_in = 1'b0;
    miss("inv_idle", 32'h40, 32'h40, 32'h411);
    query(32'h180);
    inv_all_in = 1'b1;
    tick();
    inv_all_in = 1'b0;
    ret(32'h180);
    chk("inv_wait_en", {31'd0, IF_dout_en}, 32'd1);
    chk("inv_wait_word", IF_dout, 32'h1811);
    miss("inv_wait_re", 32'h180, 32'h180, 32'h1811);
    hit("inv_wait_fill", 32'h180, 32'h1811);
    inv_all_in = 1'b1;
    query(32'h180);
    inv_all_in = 1'b0;
    chk("inv_q_miss", {31'd0, MC_query_en}, 32'd1);
    tick();
    ret(32'h180);
    query(32'h300);
    chk("ar_mcq_pre", {31'd0, MC_query_en}, 32'd1);
    #2 rst_in = 1'b0;
    #1;
    chk("ar_mcq", {31'd0, MC_query_en}, 32'd0);
    chk("ar_mca", MC_query_addr, 32'd0);
    chk("ar_dout_en", {31'd0, IF_dout_en}, 32'd0);
    chk("ar_dout", IF_dout, 32'd0);
    #3 rst_in = 1'b1;
    ret(32'h300);
    chk("ar_stray", {31'd0, IF_dout_en}, 32'd0);
    miss("ar_cleared", 32'h180, 32'h180, 32'h1811);
    tick();
    rdy_in = 1'b0;
    IF_query_en = 1'b1;
    IF_query_addr = 32'h180;
    tick();
    chk("stall_none", {31'd0, IF_dout_en}, 32'd0);
    rdy_in = 1'b1;
    tick();
    chk("stall_en", {31'd0, IF_dout_en}, 32'd1);
    chk("stall_word", IF_dout, 32'h1811);
    IF_query_addr = 32'h184;
    tick();
    chk("b2b_en", {31'd0, IF_dout_en}, 32'd1);
    chk("b2b_word", IF_dout, 32'h1822);
    IF_query_en = 1'b0;
    tick();
    chk("b2b_end", {31'd0, IF_dout_en}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative instruction cache between instruction fetch (IF) and the memory controller (MC), replacing the direct-mapped ICache. It supports configurable sets, ways and line size, with full-tag compare and round-robin replacement. A flush input abandons an in-flight fetch without corrupting the array, and an invalidate-all input serves fence.i. There is one outstanding miss at a time; the MC request/return protocol matches ICache.

## Interface
- SET_WIDTH, 2: log2 of set count (4 sets).
- WAY_WIDTH, 1: log2 of associativity (2 ways); 0 gives direct-mapped.
- BLOCK_WIDTH, 2: log2 of words per line (4 words, 16 B).
- TAG_WIDTH, 32-SET_WIDTH-BLOCK_WIDTH-2: derived; never overridden.
- clk_in  input  1  sole clock, rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global enable; low freezes all state and outputs.
- flush_in  input  1  abandon current fetch (mispredict/redirect).
- inv_all_in  input  1  invalidate every line.
- IF_query_en  input  1  fetch request, sampled in IDLE only.
- IF_query_addr  input  32  fetch address; bits [1:0] ignored.
- IF_dout_en  output  1  one-cycle pulse, IF_dout valid.
- IF_dout  output  32  instruction word.
- MC_query_en  output  1  one-cycle line-fill request.
- MC_query_addr  output  32  line-aligned address {addr[31:BLOCK_WIDTH+2], 0}.
- MC_data_en  input  1  line-fill return strobe.
- MC_data  input  32<<BLOCK_WIDTH  line data; word k at [32k+31:32k].

## Operation
- Address split: tag=[31:SET_WIDTH+BLOCK_WIDTH+2], set=[SET_WIDTH+BLOCK_WIDTH+1:BLOCK_WIDTH+2], offset=[BLOCK_WIDTH+1:2].
- Storage per set and way: valid bit, TAG_WIDTH tag, line. Per set: WAY_WIDTH-bit victim pointer.
- Hit means any way in the set is valid with an equal tag. At most one way can match. Output word = line[32*offset +: 32].
- States:
  - IDLE: query and hit → pulse IF_dout_en. Query and miss → latch addr, pulse MC_query_en, go to WAIT.
  - WAIT: MC_data_en → fill, pulse IF_dout_en with the latched-offset word, go to IDLE. flush_in → go to DRAIN.
  - DRAIN: MC_data_en → fill, no IF output, go to IDLE.
- Fill way: the lowest-index invalid way in the set. If every way is valid, use the victim pointer, then increment the pointer mod 2^WAY_WIDTH. Hits do not touch the pointer.
- inv_all_in clears all valid bits. If it is asserted in WAIT/DRAIN, or coincides with MC_data_en, the pending fill is not written (the data still goes to IF in WAIT). A sticky flag holds this until the fill returns.
- IF_query_en in WAIT/DRAIN is ignored. IF re-issues the request after redirect or after the data returns.
- Simultaneous events:
  - flush_in and IF_query_en in IDLE: query dropped, no MC request.
  - flush_in and MC_data_en in WAIT: line written, no IF output.
  - inv_all_in and IF_query_en in IDLE: invalidation applied first, so the query misses.
- Reset (async, any state): state=IDLE, all valid=0, victim pointers=0, IF_dout_en=0, IF_dout=0, MC_query_en=0, MC_query_addr=0, inval flag=0. A late MC_data_en after reset is ignored in IDLE.

## Timing
- All outputs are registered.
- Hit: query at cycle t → IF_dout_en=1 at t+1 for exactly one cycle. Back-to-back hits give one word per cycle.
- Miss: query at t → MC_query_en=1 at t+1 only, with MC_query_addr held until the next miss. MC_data_en at cycle m → IF_dout_en at m+1, and the line is visible to a hit queried at m+1.
- IF_dout holds its last value when IF_dout_en=0.
- rdy_in=0: no state update and no sampling of inputs, including MC_data_en, flush_in and inv_all_in. MC shares rdy_in.

## Test plan
Defaults apply; addresses 0x00, 0x40 and 0x80 all map to set 0.
- Cold miss 0x08: MC_query_en one cycle with addr 0x00. Return words 0x11,0x22,0x33,0x44 → IF_dout=0x33 one cycle after MC_data_en. Then query 0x0C → 0x44 at t+1 with no MC request.
- Replacement: fill 0x00 (way0), then 0x40 (way1), then 0x80 (evicts way0, pointer→1). Query 0x40 → hit. Query 0x00 → miss, refills into way1.
- Flush: miss on 0x100, then flush_in in WAIT, then MC_data_en → no IF_dout_en, state IDLE. Re-query 0x100 → hit at t+1.
- Invalidate: with 0x40 cached, pulse inv_all_in → query 0x40 misses. Pulse inv_all_in during an outstanding miss → data is delivered, and a re-query of the same address misses.
- Async reset: drop rst_in in WAIT between clock edges → all outputs 0 immediately. After release, a stray MC_data_en produces no IF_dout_en.
- Stall: rdy_in=0 on the cycle of a hitting query → no output. Raise rdy_in with the query held → IF_dout_en one cycle later.
